sdc_spi_responder: RTL and testbench

- SPI-mode SD card responder: the card-side end of the SD SPI command protocol.
- Oversamples SCK/CS/MOSI on the system clock, deframes 48-bit command frames and returns R1/R7 responses on MISO.
- Models the card's idle → ready init flow: CMD0, CMD8, CMD55, ACMD41.
- Used as the bench/loopback partner for the host-side init and command blocks, and synthesizable for on-board self-test.

---
 rtl/sdc_spi_responder.sv | 260 ++++++++++++++++++++++++++
 tb/tb_sdc_spi_responder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sdc_spi_responder.sv
// rtl/sdc_spi_responder.sv - SD card SPI-mode command responder (card side)
//
// Oversamples the host SPI bus (mode 0) on i_clk, deframes 48-bit commands,
// tracks the CMD0/CMD8/CMD55/ACMD41 idle->ready flow and returns R1/R7 on MISO.
//
// Ports:
//   i_clk        system clock, at least 4x the SCK rate
//   i_rst        asynchronous active-high reset
//   i_sck        SPI clock from host (mode 0, asynchronous to i_clk)
//   i_cs         chip select, active low
//   i_mosi       host -> card data
//   o_miso       card -> host data, idles high
//   o_idle       card in idle state (R1 bit 0)
//   o_ready      initialization complete
//   o_cmd_valid  one-cycle pulse per accepted well-formed frame
//   o_cmd_index  index of the last accepted frame

module sdc_spi_responder #(
  parameter int NCR_BYTES   = 1,
  parameter int ACMD41_BUSY = 2,
  parameter int CRC_CHECK   = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sck,
  input  logic       i_cs,
  input  logic       i_mosi,
  output logic       o_miso,
  output logic       o_idle,
  output logic       o_ready,
  output logic       o_cmd_valid,
  output logic [5:0] o_cmd_index
);

  typedef enum logic [1:0] {ST_WAIT, ST_RX, ST_NCR, ST_TX} state_t;

  localparam logic [6:0] NCR_LAST  = 7'(NCR_BYTES * 8 - 1);
  localparam logic [7:0] BUSY_INIT = 8'(ACMD41_BUSY);

  state_t      state_q, state_d;
  logic [1:0]  sck_sync_q, sck_sync_d;
  logic [1:0]  cs_sync_q, cs_sync_d;
  logic [1:0]  mosi_sync_q, mosi_sync_d;
  logic        sck_prev_q, sck_prev_d;
  logic [6:0]  bit_cnt_q, bit_cnt_d;
  logic [46:0] shift_q, shift_d;
  logic [39:0] resp_q, resp_d;
  logic [6:0]  resp_len_q, resp_len_d;
  logic        miso_q, miso_d;
  logic        idle_q, idle_d;
  logic        ready_q, ready_d;
  logic        app_q, app_d;
  logic [7:0]  busy_q, busy_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [5:0]  cmd_index_q, cmd_index_d;

  logic        sck_s, cs_s, mosi_s;
  logic        sck_rise, sck_fall;
  logic [47:0] frame;
  logic [5:0]  frame_idx;
  logic        frame_ok;
  logic        crc_err;
  logic [6:0]  frame_crc;

  // CRC7, polynomial x^7 + x^3 + 1, MSB first.
  function automatic logic [6:0] crc7_calc(input logic [39:0] data);
    logic [6:0] crc;
    logic       fb;
    crc = 7'h00;
    for (int i = 39; i >= 0; i--) begin
      fb  = data[i] ^ crc[6];
      crc = {crc[5:0], 1'b0};
      if (fb) crc = crc ^ 7'h09;
    end
    return crc;
  endfunction

  assign sck_s    = sck_sync_q[1];
  assign cs_s     = cs_sync_q[1];
  assign mosi_s   = mosi_sync_q[1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  // Frame as it will look once the current MOSI bit is shifted in.
  assign frame     = {shift_q, mosi_s};
  assign frame_idx = frame[45:40];
  assign frame_ok  = ~frame[47] & frame[46] & frame[0];
  assign frame_crc = crc7_calc(frame[47:8]);
  assign crc_err   = (CRC_CHECK != 0) && ((frame_idx == 6'd0) || (frame_idx == 6'd8))
                     && (frame_crc != frame[7:1]);

  always_comb begin
    sck_sync_d  = {sck_sync_q[0], i_sck};
    cs_sync_d   = {cs_sync_q[0], i_cs};
    mosi_sync_d = {mosi_sync_q[0], i_mosi};
    sck_prev_d  = sck_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    resp_d      = resp_q;
    resp_len_d  = resp_len_q;
    miso_d      = miso_q;
    idle_d      = idle_q;
    ready_d     = ready_q;
    app_d       = app_q;
    busy_d      = busy_q;
    cmd_valid_d = 1'b0;
    cmd_index_d = cmd_index_q;

    if (cs_s) begin
      state_d   = ST_WAIT;
      miso_d    = 1'b1;
      bit_cnt_d = 7'd0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          if (sck_rise && !mosi_s) begin
            shift_d   = 47'd0;
            bit_cnt_d = 7'd1;
            state_d   = ST_RX;
          end
        end

        ST_RX: begin
          if (sck_rise) begin
            shift_d   = frame[46:0];
            bit_cnt_d = bit_cnt_q + 7'd1;
            if (bit_cnt_q == 7'd47) begin
              bit_cnt_d = 7'd0;
              if (!frame_ok) begin
                state_d = ST_WAIT;
              end else begin
                cmd_valid_d = 1'b1;
                cmd_index_d = frame_idx;
                state_d     = ST_NCR;
                resp_len_d  = 7'd8;
                // Unused low bits of a 1-byte response stay high.
                resp_d      = 40'hFF_FFFF_FFFF;
                if (crc_err) begin
                  resp_d[39:32] = {7'b0000100, idle_q};
                end else begin
                  case (frame_idx)
                    6'd0: begin
                      idle_d        = 1'b1;
                      ready_d       = 1'b0;
                      busy_d        = BUSY_INIT;
                      app_d         = 1'b0;
                      resp_d[39:32] = 8'h01;
                    end
                    6'd8: begin
                      app_d      = 1'b0;
                      resp_len_d = 7'd40;
                      resp_d     = {7'b0, idle_q, 16'h0000, 4'h0, frame[19:16], frame[15:8]};
                    end
                    6'd55: begin
                      app_d         = 1'b1;
                      resp_d[39:32] = {7'b0, idle_q};
                    end
                    6'd41: begin
                      app_d = 1'b0;
                      if (!app_q) begin
                        resp_d[39:32] = {7'b0000010, idle_q};
                      end else if (busy_q != 8'd0) begin
                        busy_d        = busy_q - 8'd1;
                        resp_d[39:32] = 8'h01;
                      end else begin
                        idle_d        = 1'b0;
                        ready_d       = 1'b1;
                        resp_d[39:32] = 8'h00;
                      end
                    end
                    default: begin
                      app_d         = 1'b0;
                      resp_d[39:32] = {7'b0000010, idle_q};
                    end
                  endcase
                end
              end
            end
          end
        end

        ST_NCR: begin
          if (sck_fall) begin
            miso_d = 1'b1;
            if (bit_cnt_q == NCR_LAST) begin
              bit_cnt_d = 7'd0;
              state_d   = ST_TX;
            end else begin
              bit_cnt_d = bit_cnt_q + 7'd1;
            end
          end
        end

        ST_TX: begin
          // One extra falling edge after the last bit releases MISO, so the
          // final bit is held through the host's sampling edge.
          if (sck_fall) begin
            if (bit_cnt_q == resp_len_q) begin
              miso_d    = 1'b1;
              bit_cnt_d = 7'd0;
              state_d   = ST_WAIT;
            end else begin
              miso_d    = resp_q[39];
              resp_d    = {resp_q[38:0], 1'b1};
              bit_cnt_d = bit_cnt_q + 7'd1;
            end
          end
        end

        default: state_d = ST_WAIT;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_WAIT;
      sck_sync_q  <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b11;
      sck_prev_q  <= 1'b0;
      bit_cnt_q   <= 7'd0;
      shift_q     <= 47'd0;
      resp_q      <= 40'hFF_FFFF_FFFF;
      resp_len_q  <= 7'd8;
      miso_q      <= 1'b1;
      idle_q      <= 1'b1;
      ready_q     <= 1'b0;
      app_q       <= 1'b0;
      busy_q      <= BUSY_INIT;
      cmd_valid_q <= 1'b0;
      cmd_index_q <= 6'd0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_prev_q  <= sck_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      resp_q      <= resp_d;
      resp_len_q  <= resp_len_d;
      miso_q      <= miso_d;
      idle_q      <= idle_d;
      ready_q     <= ready_d;
      app_q       <= app_d;
      busy_q      <= busy_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_index_q <= cmd_index_d;
    end
  end

  assign o_miso      = miso_q;
  assign o_idle      = idle_q;
  assign o_ready     = ready_q;
  assign o_cmd_valid = cmd_valid_q;
  assign o_cmd_index = cmd_index_q;

endmodule

// File: tb/tb_sdc_spi_responder.sv
// tb/tb_sdc_spi_responder.sv - scoreboard bench for sdc_spi_responder
module tb_sdc_spi_responder;

  localparam int NCR = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       cs = 1'b1;
  logic       mosi = 1'b1;
  logic       miso;
  logic       idle;
  logic       ready;
  logic       cmd_valid;
  logic [5:0] cmd_index;

  int total = 0;
  int bad = 0;

  logic [7:0] byte_q[$];
  logic [5:0] idx_q[$];
  logic       rd_en = 1'b0;

  sdc_spi_responder #(
    .NCR_BYTES  (NCR),
    .ACMD41_BUSY(2),
    .CRC_CHECK  (1)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_sck      (sck),
    .i_cs       (cs),
    .i_mosi     (mosi),
    .o_miso     (miso),
    .o_idle     (idle),
    .o_ready    (ready),
    .o_cmd_valid(cmd_valid),
    .o_cmd_index(cmd_index)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // MISO byte monitor: collects bits on SCK rise while the host is reading.
  initial begin
    logic [7:0] rx;
    logic [7:0] exp;
    int nb;
    rx = 8'h00;
    nb = 0;
    forever begin
      @(posedge sck);
      if (rd_en) begin
        rx = {rx[6:0], miso};
        nb++;
        if (nb == 8) begin
          nb = 0;
          total++;
          if (byte_q.size() == 0) begin
            bad++;
            $display("FAIL miso_byte: got %0h with nothing expected", rx);
          end else begin
            exp = byte_q.pop_front();
            if (rx !== exp) begin
              bad++;
              $display("FAIL miso_byte: got %0h expected %0h", rx, exp);
            end
          end
        end
      end
    end
  end

  // Command-accept monitor.
  initial begin
    logic [5:0] exp;
    forever begin
      @(negedge clk);
      if (cmd_valid) begin
        total++;
        if (idx_q.size() == 0) begin
          bad++;
          $display("FAIL cmd_valid: unexpected pulse index %0d", cmd_index);
        end else begin
          exp = idx_q.pop_front();
          if (cmd_index !== exp) begin
            bad++;
            $display("FAIL cmd_index: got %0d expected %0d", cmd_index, exp);
          end
        end
      end
    end
  end

  task automatic xfer_bits(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      #50 sck = 1'b1;
      #50 sck = 1'b0;
    end
  endtask

  task automatic read_bytes(input int n);
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) xfer_bits(48'hFF, 8);
    rd_en = 1'b0;
  endtask

  // Issue one command; queue its index and the filler + response bytes.
  task automatic do_cmd(input logic [47:0] f, input logic [39:0] resp, input int nresp);
    idx_q.push_back(f[45:40]);
    for (int i = 0; i < NCR; i++) byte_q.push_back(8'hFF);
    for (int i = 0; i < nresp; i++) byte_q.push_back(resp[39 - 8*i -: 8]);
    xfer_bits(f, 48);
    read_bytes(NCR + nresp);
  endtask

  localparam logic [47:0] CMD0    = 48'h40_0000_0000_95;
  localparam logic [47:0] CMD8    = 48'h48_0000_01AA_87;
  localparam logic [47:0] CMD8BAD = 48'h48_0000_01AA_01;
  localparam logic [47:0] CMD55   = 48'h77_0000_0000_01;
  localparam logic [47:0] ACMD41  = 48'h69_4000_0000_01;
  localparam logic [47:0] CMD17   = 48'h51_0000_0000_01;

  initial begin
    #22;
    check("rst_miso", 64'(miso), 64'd1);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_valid", 64'(cmd_valid), 64'd0);
    check("rst_index", 64'(cmd_index), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #100 cs = 1'b0;
    #100;

    do_cmd(CMD0, 40'h01_0000_0000, 1);
    check("idle_after_cmd0", 64'(idle), 64'd1);
    do_cmd(CMD8, 40'h01_0000_01AA, 5);
    do_cmd(CMD8BAD, 40'h09_0000_0000, 1);
    do_cmd(ACMD41, 40'h05_0000_0000, 1);

    for (int k = 0; k < 3; k++) begin
      do_cmd(CMD55, 40'h01_0000_0000, 1);
      do_cmd(ACMD41, (k < 2) ? 40'h01_0000_0000 : 40'h00_0000_0000, 1);
      if (k == 1) check("ready_before_third", 64'(ready), 64'd0);
    end
    check("ready_after_init", 64'(ready), 64'd1);
    check("idle_after_init", 64'(idle), 64'd0);

    do_cmd(CMD17, 40'h04_0000_0000, 1);

    // Aborted frame: 20 bits of CMD0, then CS high.
    xfer_bits(CMD0 >> 28, 20);
    cs = 1'b1;
    #100 cs = 1'b0;
    #100;
    do_cmd(CMD8, 40'h00_0000_01AA, 5);
    check("ready_after_abort", 64'(ready), 64'd1);

    // Reset in the middle of an R7 response (filler, R1, then 4 bits of 0x00).
    idx_q.push_back(6'd8);
    xfer_bits(CMD8, 48);
    xfer_bits(48'hFFFF, 16);
    xfer_bits(48'hF, 4);
    #40;
    check("miso_mid_tx", 64'(miso), 64'd0);
    rst = 1'b1;
    #1;
    check("miso_in_reset", 64'(miso), 64'd1);
    check("ready_in_reset", 64'(ready), 64'd0);
    #19 rst = 1'b0;
    #10;
    check("idle_after_reset", 64'(idle), 64'd1);
    check("ready_after_reset", 64'(ready), 64'd0);
    cs = 1'b1;
    #100 cs = 1'b0;
    #100;
    do_cmd(CMD0, 40'h01_0000_0000, 1);

    #300;
    check("bytes_left", 64'(byte_q.size()), 64'd0);
    check("cmds_left", 64'(idx_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
